// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer driving one external bit_alu slice, LSB first, one bit per clock.
// Optional macro SERIAL_ALU_OPCNT_EN adds a 16-bit completed-operation counter output.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_ctrl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_less,
  output logic             slice_a_invert,
  output logic             slice_b_invert,
  output logic             slice_carry_in,
  output logic [1:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_carry_out
`ifdef SERIAL_ALU_OPCNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [3:0]       ctrl_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, set_q, ready_q, done_q, zero_q, overflow_q;
  logic             is_slt, last_bit;

  assign is_slt   = (ctrl_q[1:0] == 2'b11);
  assign last_bit = (idx_q == IDX_W'(WIDTH-1));

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

  // Slice inputs are decoded from registered state only, so they are glitch-free per cycle.
  always_comb begin
    slice_a         = 1'b0;
    slice_b         = 1'b0;
    slice_less      = 1'b0;
    slice_a_invert  = 1'b0;
    slice_b_invert  = 1'b0;
    slice_carry_in  = 1'b0;
    slice_operation = 2'b00;
    if (state_q == RUN) begin
      slice_a         = a_q[idx_q];
      slice_b         = b_q[idx_q];
      slice_a_invert  = ctrl_q[3];
      slice_b_invert  = ctrl_q[2];
      slice_carry_in  = carry_q;
      slice_operation = is_slt ? 2'b10 : ctrl_q[1:0];
    end else if (state_q == FIX) begin
      slice_operation = 2'b11;
      slice_less      = set_q;
    end
  end

  // Next result, so zero can be registered alongside the final bit.
  always_comb begin
    result_d = result_q;
    if (state_q == RUN)
      result_d[idx_q] = is_slt ? 1'b0 : slice_result;
    else if (state_q == FIX)
      result_d[0] = slice_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      set_q      <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q        <= src_a;
            b_q        <= src_b;
            ctrl_q     <= alu_ctrl;
            idx_q      <= '0;
            carry_q    <= alu_ctrl[2];
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= slice_carry_out;
          if (last_bit) begin
            // MSB carry-in vs carry-out gives signed overflow; set is the true sign of A-B.
            overflow_q <= ctrl_q[1] & (carry_q ^ slice_carry_out);
            set_q      <= slice_result ^ carry_q ^ slice_carry_out;
            if (is_slt) begin
              state_q <= FIX;
            end else begin
              zero_q  <= (result_d == '0);
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        FIX: begin
          result_q <= result_d;
          zero_q   <= (result_d == '0);
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_OPCNT_EN
  logic [15:0] op_count_q;
  assign op_count = op_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                op_count_q <= '0;
    else if (state_q == DONE)  op_count_q <= op_count_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl with a behavioural bit_alu slice attached.
module tb_bit_serial_alu_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0, result;
  logic [3:0]   alu_ctrl = '0;
  logic         ready, done, zero, overflow;
  logic         s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_res, s_cout;
  logic [1:0]   s_op;
`ifdef SERIAL_ALU_OPCNT_EN
  logic [15:0]  op_count;
`endif

  bit_serial_alu_ctrl #(.WIDTH(W), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_a(src_a), .src_b(src_b),
    .alu_ctrl(alu_ctrl), .ready(ready), .done(done), .result(result),
    .zero(zero), .overflow(overflow), .slice_a(s_a), .slice_b(s_b),
    .slice_less(s_less), .slice_a_invert(s_ainv), .slice_b_invert(s_binv),
    .slice_carry_in(s_cin), .slice_operation(s_op), .slice_result(s_res),
    .slice_carry_out(s_cout)
`ifdef SERIAL_ALU_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural one-bit MIPS ALU slice.
  logic ae, be;
  always_comb begin
    ae     = s_a ^ s_ainv;
    be     = s_b ^ s_binv;
    s_cout = (ae & be) | (ae & s_cin) | (be & s_cin);
    case (s_op)
      2'b00:   s_res = ae & be;
      2'b01:   s_res = ae | be;
      2'b10:   s_res = ae ^ be ^ s_cin;
      default: s_res = s_less;
    endcase
  end

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, W'(zero), W'(e.z));
        chk({e.name, "_overflow"}, W'(overflow), W'(e.ovf));
        chk({e.name, "_latency"}, W'(cyc - e.acc + 1), W'(e.lat));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                       input string name, input logic [W-1:0] res, input logic z,
                       input logic ovf, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    src_a = a; src_b = b; alu_ctrl = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.name = name; e.res = res; e.z = z; e.ovf = ovf; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(ready), 1);
    chk("rst_done", W'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_zero_ovf", {zero, overflow}, 0);
    chk("rst_slice", {s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_op}, 0);
    rst_n = 1'b1;

    issue(32'd5, 32'd3, 4'b0010, "add", 32'd8, 1'b0, 1'b0, 33);                   wait_drain();
    issue(32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0110, "sub_ovf", 32'h80000000, 1'b0, 1'b1, 33); wait_drain();
    issue(32'h1234, 32'h1234, 4'b0110, "sub_zero", 32'd0, 1'b1, 1'b0, 33);         wait_drain();
    issue(32'hFFFFFFFF, 32'd1, 4'b0111, "slt_neg", 32'd1, 1'b0, 1'b0, 34);         wait_drain();
    issue(32'h7FFFFFFF, 32'h80000000, 4'b0111, "slt_ovf", 32'd0, 1'b1, 1'b1, 34);  wait_drain();
    issue(32'hF0F0, 32'h0FF0, 4'b0000, "and", 32'h00F0, 1'b0, 1'b0, 33);           wait_drain();
    issue(32'hF0F0, 32'h0FF0, 4'b0001, "or", 32'hFFF0, 1'b0, 1'b0, 33);            wait_drain();
    issue(32'd0, 32'd0, 4'b1100, "nor", 32'hFFFFFFFF, 1'b0, 1'b0, 33);             wait_drain();
    chk("idle_slice", {s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_op}, 0);

    // Start while busy must be ignored.
    issue(32'd100, 32'd23, 4'b0010, "busy_start", 32'd123, 1'b0, 1'b0, 33);
    repeat (3) @(negedge clk);
    src_a = 32'hDEAD; src_b = 32'hBEEF; alu_ctrl = 4'b0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_drain();

    // Reset in the middle of an operation abandons it.
    issue(32'd7, 32'd9, 4'b0010, "aborted", 32'd16, 1'b0, 1'b0, 33);
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    sb.delete();
    chk("abort_ready", W'(ready), 1);
    chk("abort_result", result, 0);
    chk("abort_done", W'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_ready", W'(ready), 1);

`ifdef SERIAL_ALU_OPCNT_EN
    chk("opcnt_after_reset", W'(op_count), 0);
    issue(32'd1, 32'd1, 4'b0010, "cnt1", 32'd2, 1'b0, 1'b0, 33); wait_drain();
    issue(32'd1, 32'd2, 4'b0001, "cnt2", 32'd3, 1'b0, 1'b0, 33); wait_drain();
    issue(32'd3, 32'd1, 4'b0000, "cnt3", 32'd1, 1'b0, 1'b0, 33); wait_drain();
    chk("opcnt_three", W'(op_count), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Bit-serial sequencer that drives one external bit_alu slice to perform a full WIDTH-bit MIPS ALU operation, one bit per clock, LSB first. It latches the operands and a 4-bit ALU control, then drives the slice's a/b/less/invert/carry_in/operation inputs. It collects the slice's result and carry_out, and chains the carry through an internal register. It reports the result, zero and overflow, and sits in a low-area multi-cycle datapath in place of a WIDTH-slice ripple ALU.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
IDX_W, 5, width of bit index counter (>= clog2(WIDTH))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
src_a  input  WIDTH  operand A, latched on accept
src_b  input  WIDTH  operand B, latched on accept
alu_ctrl  input  4  [3]=Ainvert, [2]=Bnegate (b_invert and bit-0 carry_in), [1:0]=operation; latched on accept
ready  output  1  high in IDLE
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  operation result
zero  output  1  result==0
overflow  output  1  signed overflow (arith ops only)
slice_a / slice_b / slice_less  output  1 each  to slice a, b, less
slice_a_invert / slice_b_invert / slice_carry_in  output  1 each  to slice
slice_operation  output  2  to slice operation
slice_result  input  1  from slice result
slice_carry_out  input  1  from slice carry_out

Behaviour:
- Reset: state=IDLE, ready=1, done=0, result=0, zero=0, overflow=0, all slice_* outputs=0, idx=0, carry=0. Reset mid-operation abandons the op; no done.
- Slice contract: combinational, op 00=AND, 01=OR, 10=ADD, 11=pass less.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1, latch src_a/src_b/alu_ctrl, idx<=0, carry<=alu_ctrl[2], clear result, go to RUN. start outside IDLE is ignored.
- RUN: slice_a=A[idx], slice_b=B[idx], slice_a_invert=ctrl[3], slice_b_invert=ctrl[2], slice_carry_in=carry, slice_less=0.
- RUN: slice_operation=ctrl[1:0], except SLT (ctrl[1:0]=11), which drives 10 (ADD).
- RUN, each edge: result[idx]<=slice_result (forced 0 for SLT), carry<=slice_carry_out, idx++.
- At idx=WIDTH-1: capture cin_msb=carry, cout_msb=slice_carry_out, sum_msb=slice_result.
- At idx=WIDTH-1: overflow<=cin_msb^cout_msb when ctrl[1]=1, else 0; set<=sum_msb^(cin_msb^cout_msb).
- Leaving RUN after idx=WIDTH-1: go to FIX if SLT, else DONE.
- FIX (SLT only): drive slice_operation=11, slice_less=set, other slice inputs 0; result[0]<=slice_result; go to DONE.
- DONE: done=1 for exactly one cycle; zero=(result==0); go to IDLE.
- Latency: start accepted at edge 0; done high in cycle WIDTH+1 (non-SLT) or WIDTH+2 (SLT).
- result/zero/overflow hold until the next accepted start; zero/overflow are valid from done onward.
- slice_* outputs are all 0 in IDLE and DONE.
- idx does not wrap beyond WIDTH-1; ctrl codes outside the MIPS set execute per field decode.

Optional Feature:
SERIAL_ALU_OPCNT_EN: when defined, adds output op_count[15:0], reset 0, incremented in the DONE cycle and wrapping 0xFFFF->0. When undefined, the port and counter do not exist.

Test Plan:
- ADD: A=5, B=3, ctrl=0010 -> done at cycle 33; result=8, zero=0, overflow=0.
- SUB overflow: A=0x7FFFFFFF, B=0xFFFFFFFF, ctrl=0110 -> result=0x80000000, overflow=1; then A=B=0x1234 -> result=0, zero=1.
- SLT: A=0xFFFFFFFF, B=1, ctrl=0111 -> result=1, done at cycle 34; A=0x7FFFFFFF, B=0x80000000 -> result=0, overflow=1.
- Logic: AND 0xF0F0&0x0FF0 ctrl=0000 -> 0x00F0; OR same operands ctrl=0001 -> 0xFFF0; NOR A=B=0 ctrl=1100 -> 0xFFFFFFFF, overflow=0.
- Control: start pulsed during RUN -> ignored, first result unaffected; rst_n low at RUN cycle 10 -> ready=1, result=0, no done.
- With SERIAL_ALU_OPCNT_EN: 3 ops -> op_count=3; preload 0xFFFF via 65535 ops (or force) -> next op gives 0.
